// File: rtl/niosii_top_pio_gen.sv
// Avalon-MM general-purpose PIO: per-bit direction, synchronised inputs,
// edge capture with interrupt mask, and atomic set/clear of output bits.
module niosii_top_pio_gen #(
    parameter int unsigned      WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter int unsigned      IRQ_TYPE    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    logic             wrEn;
    logic [WIDTH-1:0] wrData;

    logic [WIDTH-1:0] dataOut_q, dataOut_d;
    logic [WIDTH-1:0] dir_q,     dir_d;
    logic [WIDTH-1:0] mask_q,    mask_d;
    logic [WIDTH-1:0] edgeCap_q, edgeCap_d;
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] inSync_q;
    logic [WIDTH-1:0] inPrev_q;

    logic [WIDTH-1:0] risingEdge;
    logic [WIDTH-1:0] fallingEdge;
    logic [WIDTH-1:0] edgeDet;
    logic [WIDTH-1:0] capClr;
    logic [WIDTH-1:0] readVal;

    assign wrEn   = chipselect && !write_n;
    assign wrData = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : gPad
            logic unusedWrBits;
            assign unusedWrBits = |writedata[31:WIDTH];
        end
    endgenerate

    // OUTSET/OUTCLR let firmware flip individual bits without a read-modify-write.
    always_comb begin
        dataOut_d = dataOut_q;
        dir_d     = dir_q;
        mask_d    = mask_q;
        if (wrEn) begin
            case (address)
                ADDR_DATA:    dataOut_d = wrData;
                ADDR_DIR:     dir_d     = wrData;
                ADDR_IRQMASK: mask_d    = wrData;
                ADDR_OUTSET:  dataOut_d = dataOut_q | wrData;
                ADDR_OUTCLR:  dataOut_d = dataOut_q & ~wrData;
                default:      ;
            endcase
        end
    end

    assign risingEdge  = inSync_q & ~inPrev_q;
    assign fallingEdge = ~inSync_q & inPrev_q;

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edgeDet = risingEdge;
        end else if (EDGE_TYPE == 1) begin
            edgeDet = fallingEdge;
        end else begin
            edgeDet = risingEdge | fallingEdge;
        end
    end

    // A fresh edge is OR-ed in after the clear so it is never lost to a racing write.
    assign capClr    = (wrEn && (address == ADDR_EDGECAP)) ? wrData : '0;
    assign edgeCap_d = (edgeCap_q & ~capClr) | edgeDet;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dataOut_q <= RESET_VALUE;
            dir_q     <= '0;
            mask_q    <= '0;
            edgeCap_q <= '0;
            s1_q      <= '0;
            inSync_q  <= '0;
            inPrev_q  <= '0;
        end else begin
            dataOut_q <= dataOut_d;
            dir_q     <= dir_d;
            mask_q    <= mask_d;
            edgeCap_q <= edgeCap_d;
            s1_q      <= in_port;
            inSync_q  <= s1_q;
            inPrev_q  <= inSync_q;
        end
    end

    always_comb begin
        readVal = '0;
        case (address)
            ADDR_DATA:    readVal = (dir_q & dataOut_q) | (~dir_q & inSync_q);
            ADDR_DIR:     readVal = dir_q;
            ADDR_IRQMASK: readVal = mask_q;
            ADDR_EDGECAP: readVal = edgeCap_q;
            default:      readVal = '0;
        endcase
    end

    always_comb begin
        readdata              = '0;
        readdata[WIDTH-1:0]   = readVal;
    end

    assign out_port = dataOut_q;
    assign out_oe   = dir_q;
    assign irq      = (IRQ_TYPE == 1) ? |(inSync_q & mask_q) : |(edgeCap_q & mask_q);

endmodule

// File: tb/tb_niosii_top_pio_gen.sv
// Scoreboard bench for niosii_top_pio_gen: three instances (rising/edge irq,
// any-edge/level irq, falling/edge irq) checked against a queue-based model.
module tb_niosii_top_pio_gen;

    localparam int unsigned W    = 10;
    localparam int unsigned MSK  = 32'h3FF;
    localparam int unsigned RSTV = 32'h155;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [W-1:0] in_port = '0;

    logic [31:0]  rdA, rdB, rdC;
    logic [W-1:0] outA, outB, outC, oeA, oeB, oeC;
    logic         irqA, irqB, irqC;

    int errCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    niosii_top_pio_gen #(.WIDTH(W), .RESET_VALUE(10'h155), .EDGE_TYPE(0), .IRQ_TYPE(0)) dutA (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdA), .in_port(in_port),
        .out_port(outA), .out_oe(oeA), .irq(irqA));

    niosii_top_pio_gen #(.WIDTH(W), .RESET_VALUE(10'h155), .EDGE_TYPE(2), .IRQ_TYPE(1)) dutB (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdB), .in_port(in_port),
        .out_port(outB), .out_oe(oeB), .irq(irqB));

    niosii_top_pio_gen #(.WIDTH(W), .RESET_VALUE(10'h155), .EDGE_TYPE(1), .IRQ_TYPE(0)) dutC (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdC), .in_port(in_port),
        .out_port(outC), .out_oe(oeC), .irq(irqC));

    // ---------------- reference model ----------------
    int unsigned mData, mDir, mMask;
    int unsigned mCap[3];
    int unsigned hist[$];
    int          edgeKind[3] = '{0, 2, 1};
    bit          levelIrq[3] = '{1'b0, 1'b1, 1'b0};

    function automatic int unsigned edgeOf(input int kind, input int unsigned s, input int unsigned p);
        int unsigned rise, fall;
        rise = s & ~p & MSK;
        fall = ~s & p & MSK;
        if (kind == 0) return rise;
        if (kind == 1) return fall;
        return rise | fall;
    endfunction

    task automatic modelReset();
        mData = RSTV;
        mDir  = 0;
        mMask = 0;
        for (int k = 0; k < 3; k++) mCap[k] = 0;
        hist = '{0, 0, 0};
    endtask

    // hist holds in_port as sampled at the last three edges, newest first;
    // the synchronised view lags two edges, the previous-sync view three.
    task automatic modelStep();
        int unsigned wd, clr;
        bit          wr;
        wr  = chipselect && !write_n;
        wd  = writedata & MSK;
        clr = (wr && address == 3'd3) ? wd : 0;
        for (int k = 0; k < 3; k++)
            mCap[k] = (mCap[k] & ~clr) | edgeOf(edgeKind[k], hist[1], hist[2]);
        if (wr) begin
            case (address)
                3'd0: mData = wd;
                3'd1: mDir  = wd;
                3'd2: mMask = wd;
                3'd4: mData = mData | wd;
                3'd5: mData = mData & ~wd;
                default: ;
            endcase
        end
        hist.push_front(32'(in_port));
        void'(hist.pop_back());
    endtask

    function automatic int unsigned expRead(input int k, input logic [2:0] a);
        case (a)
            3'd0: return ((mDir & mData) | (~mDir & hist[1])) & MSK;
            3'd1: return mDir;
            3'd2: return mMask;
            3'd3: return mCap[k];
            default: return 0;
        endcase
    endfunction

    function automatic logic expIrq(input int k);
        if (levelIrq[k]) return (hist[1] & mMask) != 0;
        return (mCap[k] & mMask) != 0;
    endfunction

    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) modelReset();
            else          modelStep();
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        logic [31:0] rdA, rdB, rdC;
        logic [9:0]  outp, oe;
        logic        irqA, irqB, irqC;
    } exp_t;

    exp_t sbQ[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chipselect && write_n) begin
                if (sbQ.size() == 0) begin
                    checkOutput("sbUnderflow", 32'd1, 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput({e.name, ".rdA"}, rdA, e.rdA);
                    checkOutput({e.name, ".rdB"}, rdB, e.rdB);
                    checkOutput({e.name, ".rdC"}, rdC, e.rdC);
                    checkOutput({e.name, ".out"}, 32'(outA), 32'(e.outp));
                    checkOutput({e.name, ".oe"}, 32'(oeA), 32'(e.oe));
                    checkOutput({e.name, ".irqA"}, 32'(irqA), 32'(e.irqA));
                    checkOutput({e.name, ".irqB"}, 32'(irqB), 32'(e.irqB));
                    checkOutput({e.name, ".irqC"}, 32'(irqC), 32'(e.irqC));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [W-1:0] inCur = '0;

    task automatic pushExpected(input string name);
        exp_t e;
        e.name = name;
        e.rdA  = expRead(0, address);
        e.rdB  = expRead(1, address);
        e.rdC  = expRead(2, address);
        e.outp = mData[9:0];
        e.oe   = mDir[9:0];
        e.irqA = expIrq(0);
        e.irqB = expIrq(1);
        e.irqC = expIrq(2);
        sbQ.push_back(e);
    endtask

    // kind: 0 idle, 1 write, 2 read
    task automatic applyStimulus(input int kind, input logic [2:0] a, input logic [31:0] d, input string name);
        @(posedge clk);
        #2;
        in_port = inCur;
        address = a;
        writedata = d;
        case (kind)
            1: begin chipselect = 1'b1; write_n = 1'b0; end
            2: begin chipselect = 1'b1; write_n = 1'b1; pushExpected(name); end
            default: begin chipselect = 1'b0; write_n = 1'b1; end
        endcase
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        applyStimulus(1, a, d, "");
    endtask

    task automatic rd(input logic [2:0] a, input string name);
        applyStimulus(2, a, $urandom, name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        errCount++;
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int kind;
        // Reset state, read while still in reset and just after release.
        rd(3'd1, "rstDir");
        rd(3'd2, "rstMask");
        rd(3'd3, "rstCap");
        @(posedge clk); #2; reset_n = 1'b1; chipselect = 1'b0;
        rd(3'd1, "postDir");
        rd(3'd3, "postCap");

        // Output path: DATA, OUTSET, OUTCLR.
        wr(3'd1, 32'h3FF);
        wr(3'd0, 32'h0F0);
        rd(3'd0, "data0F0");
        wr(3'd4, 32'h00F);
        rd(3'd0, "set0FF");
        wr(3'd5, 32'h0C0);
        rd(3'd0, "clr03F");
        rd(3'd4, "readSet");
        rd(3'd5, "readClr");
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd6, "addr6");

        // Input path through the synchroniser, upper write bits ignored.
        wr(3'd1, 32'hFFFF_FC00);
        inCur = 10'h2A0;
        for (int i = 0; i < 4; i++) rd(3'd0, "syncIn");

        // Edge capture and clear on bit 0.
        wr(3'd3, 32'h3FF);
        wr(3'd2, 32'h001);
        rd(3'd3, "capCleared");
        inCur = 10'h2A1;
        for (int i = 0; i < 3; i++) rd(3'd3, "pulseHigh");
        inCur = 10'h2A0;
        rd(3'd3, "pulseLow");
        wr(3'd3, 32'h001);
        rd(3'd3, "capClr");
        for (int i = 0; i < 4; i++) rd(3'd3, "settle");

        // New edge landing on the same edge as the EDGECAP clear.
        wr(3'd3, 32'h3FF);
        inCur = 10'h2A1;
        applyStimulus(0, 3'd0, 32'd0, "");
        wr(3'd3, 32'h001);
        rd(3'd3, "edgeBeatsClr");
        rd(3'd3, "edgeBeatsClr2");

        // Level interrupt on bit 9.
        wr(3'd2, 32'h200);
        inCur = 10'h201;
        for (int i = 0; i < 3; i++) rd(3'd0, "levelHigh");
        inCur = 10'h001;
        for (int i = 0; i < 3; i++) rd(3'd0, "levelLow");

        // Asynchronous reset mid-operation, observed before any clock edge.
        wr(3'd1, 32'h0AA);
        wr(3'd2, 32'h3FF);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        address = 3'd1; chipselect = 1'b1; write_n = 1'b1;
        pushExpected("midReset");
        inCur = '0;
        rd(3'd2, "inReset");
        @(posedge clk); #2; reset_n = 1'b1; chipselect = 1'b0;

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) inCur = W'($urandom);
            kind = $urandom_range(0, 2);
            applyStimulus(kind, 3'($urandom_range(0, 7)), $urandom, "rand");
        end

        applyStimulus(0, 3'd0, 32'd0, "");
        applyStimulus(0, 3'd0, 32'd0, "");
        checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/niosii_top_pio_gen.md
# niosii_top_pio_gen

Parametrised Avalon-MM parallel I/O port for the Nios II system: a bidirectional GPIO bank of up to 32 bits with a per-bit direction register, a two-flop input synchroniser, per-bit edge capture, an interrupt mask and atomic set/clear of output bits. It sits on the data master as a zero-wait-state slave. It is the generalised successor of the fixed 10-bit output-only PIO and supersedes it for new LED, switch and button banks.

## Interface
- WIDTH, 10, number of I/O bits (1..32)
- RESET_VALUE, 0, reset value of the output data register (WIDTH bits)
- EDGE_TYPE, 0, edge that sets a capture bit: 0 rising, 1 falling, 2 any
- IRQ_TYPE, 0, 0 = edge (irq from capture bits), 1 = level (irq from synchronised input)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational, zero wait states
- in_port  in  WIDTH  external inputs, asynchronous to clk
- out_port  out  WIDTH  output data register
- out_oe  out  WIDTH  output enable per bit (= direction register)
- irq  out  1  active-high interrupt request

## Operation
- Register map (word address), bits above WIDTH-1 read 0 and ignore writes:
  - 0 DATA: write loads data_out; read returns per bit dir ? data_out : in_sync
  - 1 DIR: 1 = output; read/write
  - 2 IRQMASK: read/write
  - 3 EDGECAP: read capture bits; write 1 clears the bit, 0 leaves it unchanged
  - 4 OUTSET: write ORs writedata into data_out; read 0
  - 5 OUTCLR: write clears data_out bits where writedata is 1; read 0
  - 6, 7: read 0, writes ignored
- Write is active when chipselect && !write_n, committed at the rising edge of clk.
- Synchroniser: s1 <= in_port, in_sync <= s1; in_prev <= in_sync each cycle.
- Edge detect per bit: rising = in_sync & ~in_prev; falling = ~in_sync & in_prev; EDGE_TYPE selects rising, falling or their OR.
- Capture: edgecap <= (edgecap & ~clr) | edge, where clr is the EDGECAP write mask; a detected edge wins over a simultaneous clear of the same bit.
- irq = |(edgecap & mask) for IRQ_TYPE 0, |(in_sync & mask) for IRQ_TYPE 1. It is combinational from registers, so no glitch from bus inputs.
- The capture register runs in both IRQ_TYPE modes.
- Reset values: data_out = RESET_VALUE, dir = 0 (all inputs), mask = 0, edgecap = 0, s1/in_sync/in_prev = 0, hence out_port = RESET_VALUE, out_oe = 0, irq = 0.
- If in_port is held high through reset, a rising edge is captured after release. This is required behaviour; firmware clears EDGECAP at init.

## Timing
- Read: readdata is valid in the same cycle as address/chipselect. Read latency 0.
- Write: new data_out, dir and mask are visible on out_port, out_oe and readdata the cycle after the write edge.
- in_port change to in_sync: 2 clk edges.
- in_port change to edgecap bit set and irq asserted: 3 clk edges.
- EDGECAP clear: irq deasserts the cycle after the write unless a new edge lands on the same edge.
- Input pulses shorter than one clk period may be missed. Only transitions seen by in_sync count.
- Reset assertion mid-operation clears all state immediately, independent of clk.

## Test plan
- Reset with WIDTH=10, RESET_VALUE=0x155 -> out_port=0x155, out_oe=0, irq=0; read addr 1, 2 and 3 returns 0.
- Write DIR=0x3FF, DATA=0x0F0, OUTSET=0x00F, OUTCLR=0x0C0 -> out_port=0x0F0, then 0x0FF, then 0x03F; read addr 0 returns 0x03F; read addr 4 returns 0.
- With DIR=0, drive in_port=0x2A0 -> read addr 0 returns 0 before and 0x2A0 after 2 clk edges; bits above 9 read 0.
- EDGE_TYPE=0, mask=0x001: pulse in_port[0] high for 3 cycles -> EDGECAP=0x001, irq=1 on the 3rd edge; write EDGECAP 0x001 -> irq=0 the next cycle.
- Apply a new rising edge on bit 0 in the same cycle as the EDGECAP clear -> bit stays 1 and irq stays 1.
- IRQ_TYPE=1, mask=0x200: in_port[9]=1 -> irq=1 after 2 edges; in_port[9]=0 -> irq=0 after 2 edges. Assert reset_n=0 mid-test -> all outputs return to reset values without a clock.
